// File: rtl/iir1_lookahead_pipe.sv
// First-order IIR y(n) = B*x(n) + A*y(n-1) in look-ahead form, one sample per clock.
// The feedback loop closes on s(n-M), so the multiplier can be pipelined without breaking the recurrence.

module iir1_lap_mul #(
  parameter int ACC_W = 32,
  parameter int LAT   = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] p_o
);
  logic [ACC_W-1:0] pipe_q [LAT];
  logic [ACC_W-1:0] prod_d;

  // Low ACC_W bits of the product are the same for signed and unsigned operands.
  assign prod_d = a_i * b_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else if (en_i) begin
      pipe_q[0] <= prod_d;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign p_o = pipe_q[LAT-1];
endmodule

module iir1_lookahead_pipe #(
  parameter int                      X_W     = 8,
  parameter int                      Y_W     = 17,
  parameter int                      ACC_W   = 32,
  parameter logic signed [ACC_W-1:0] A       = 1,
  parameter logic signed [ACC_W-1:0] B       = 1,
  parameter int                      MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           in_valid,
  input  logic [X_W-1:0] x,
  output logic           out_valid,
  output logic [Y_W-1:0] y,
  output logic           sat
);
  localparam int M     = MUL_LAT + 1;
  localparam int L     = MUL_LAT + 3;
  localparam int CNT_W = $clog2(L + 1);

  function automatic logic [ACC_W-1:0] a_pow(input int k);
    logic [ACC_W-1:0] r;
    r    = '0;
    r[0] = 1'b1;
    for (int i = 0; i < k; i++) r = r * A;
    return r;
  endfunction

  localparam logic [ACC_W-1:0] A_M = a_pow(M);

  logic [ACC_W-1:0]   x_ext;
  logic [ACC_W-1:0]   xh_q [M];
  logic [ACC_W-1:0]   tap_p [M];
  logic [ACC_W-1:0]   f_d, f_q;
  logic [ACC_W-1:0]   fb_p;
  logic [ACC_W-1:0]   s_q;
  logic [ACC_W-Y_W:0] s_hi;
  logic               clip;
  logic [Y_W-1:0]     y_d, y_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               warm;
  logic               out_valid_q, sat_q;

  assign x_ext = ACC_W'($signed(x));

  // Feedforward taps: C_k*x(n-k), each through its own pipelined multiplier.
  for (genvar k = 0; k < M; k++) begin : g_tap
    localparam logic [ACC_W-1:0] C_K = ACC_W'(a_pow(k) * B);
    iir1_lap_mul #(.ACC_W(ACC_W), .LAT(MUL_LAT)) u_mul (
      .clk_i (clk),
      .rst_ni(rst_n),
      .clr_i (clr),
      .en_i  (in_valid),
      .a_i   (xh_q[k]),
      .b_i   (C_K),
      .p_o   (tap_p[k])
    );
  end

  // Loop registers: MUL_LAT inside this multiplier plus s_q, i.e. exactly M.
  iir1_lap_mul #(.ACC_W(ACC_W), .LAT(MUL_LAT)) u_fb_mul (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (clr),
    .en_i  (in_valid),
    .a_i   (s_q),
    .b_i   (A_M),
    .p_o   (fb_p)
  );

  always_comb begin
    f_d = '0;
    for (int k = 0; k < M; k++) f_d = f_d + tap_p[k];
  end

  // s fits in Y_W bits only when every bit from Y_W-1 upward equals the sign.
  assign s_hi = s_q[ACC_W-1:Y_W-1];

  always_comb begin
    clip = ~((&s_hi) | ~(|s_hi));
    y_d  = s_q[Y_W-1:0];
    if (clip) y_d = s_q[ACC_W-1] ? {1'b1, {(Y_W-1){1'b0}}} : {1'b0, {(Y_W-1){1'b1}}};
  end

  assign warm = (cnt_q == CNT_W'(L));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < M; k++) xh_q[k] <= '0;
      f_q         <= '0;
      s_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else if (clr) begin
      for (int k = 0; k < M; k++) xh_q[k] <= '0;
      f_q         <= '0;
      s_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else if (in_valid) begin
      xh_q[0] <= x_ext;
      for (int k = 1; k < M; k++) xh_q[k] <= xh_q[k-1];
      f_q         <= f_d;
      s_q         <= f_q + fb_p;
      y_q         <= y_d;
      if (!warm) cnt_q <= cnt_q + 1'b1;
      out_valid_q <= warm;
      if (warm && clip) sat_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign sat       = sat_q;
endmodule
